// File: rtl/dmem_responder_pkg.sv
// lsu_pkg: shared definitions for the data-memory responder.
//   - RV32I load/store funct3 width codes
//   - responder FSM state encoding
//   - helpers: byte-lane mask, access size in bytes, funct3 legality
package lsu_pkg;

  // Load width codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store width codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT1 = 2'd1,
    ST_BEAT2 = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Byte-lane mask of an access at offset 0; funct3[2] (unsigned) does not
  // change the width.
  function automatic logic [3:0] size_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_legal(input logic wren, input logic [2:0] funct3);
    if (wren) begin
      case (funct3)
        F3_SB, F3_SH, F3_SW: return 1'b1;
        default:             return 1'b0;
      endcase
    end
    case (funct3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the core (master) and dmem_responder (slave).
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. Once valid is raised, the source holds valid and its payload
// stable until that edge; ready may change freely. The responder raises
// o_req_ready only while idle and never overlaps a request with a response.
//
//   i_req_valid / o_req_ready   request channel handshake
//   i_req_wren                  1 = store, 0 = load
//   i_req_funct3                RV32I width code
//   i_req_addr                  byte address
//   i_req_wdata                 store data, right-aligned
//   o_rsp_valid / i_rsp_ready   response channel handshake
//   o_rsp_rdata                 extended load data (0 for stores and errors)
//   o_rsp_err                   illegal funct3, no RAM write performed
interface dmem_responder_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_wren;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  modport slave (
    input  i_req_valid, i_req_wren, i_req_funct3, i_req_addr, i_req_wdata,
    input  i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport master (
    output i_req_valid, i_req_wren, i_req_funct3, i_req_addr, i_req_wdata,
    output i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
endinterface

// File: rtl/dmem_bank.sv
// dmem_bank: MEM_WORDS x 32 single-port synchronous RAM with byte enables.
// Contents are not reset so the array maps onto an M10K block.
//   clk    clock, rising edge
//   en     access this cycle (read, plus write of the enabled bytes)
//   be     byte enables, lane i = wdata[8i+7:8i]
//   addr   word index
//   wdata  write data
//   rdata  read data, valid the cycle after an enabled access; holds
//          its value while en is low (read-before-write on a store)
module dmem_bank #(
  parameter int MEM_WORDS = 512,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  (* ramstyle = "M10K" *) logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for core load/store requests.
// Accepts one request in IDLE, performs one or two RAM beats (two when the
// access crosses a word boundary; the second word index wraps modulo
// MEM_WORDS), then presents a single response held until accepted.
//   i_clk        clock, rising edge
//   i_reset      asynchronous active-low reset
//   bus          request/response channels (dmem_responder_if.slave)
//   o_dbg_state  current FSM state, for observation only
module dmem_responder
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 512
) (
  input  logic            i_clk,
  input  logic            i_reset,
  dmem_responder_if.slave bus,
  output state_t          o_dbg_state
);

  localparam int AW = $clog2(MEM_WORDS);

  state_t        state;
  logic          req_ready_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic          wren_q;
  logic          split_q;
  logic [2:0]    funct3_q;
  logic [1:0]    off_q;
  logic [31:0]   wdata_q;
  logic [AW-1:0] w0_q;
  logic [31:0]   lo_q;     // w0 read data, kept for split loads

  // Request decode (IDLE only)
  logic [AW-1:0] req_word;
  logic [1:0]    req_off;
  logic [2:0]    req_size;
  logic          req_split;

  assign req_word  = bus.i_req_addr[AW+1:2];
  assign req_off   = bus.i_req_addr[1:0];
  assign req_size  = size_bytes(bus.i_req_funct3);
  // offset + size > 4 means the access spills into the next word
  assign req_split = ({1'b0, req_off} + req_size) > 3'd4;

  // Store lanes across the two-word window {w1, w0}
  logic [7:0]  be_wide;
  logic [63:0] wdata_wide;

  assign be_wide    = {4'b0000, size_mask(funct3_q)} << off_q;
  assign wdata_wide = {32'h0, wdata_q} << {off_q, 3'b000};

  // RAM port
  logic          ram_en;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic [AW-1:0] w1;

  assign w1 = w0_q + AW'(1);

  always_comb begin
    ram_en    = 1'b0;
    ram_be    = 4'b0000;
    ram_addr  = w0_q;
    ram_wdata = wdata_wide[31:0];
    case (state)
      ST_BEAT1: begin
        ram_en = 1'b1;
        ram_be = wren_q ? be_wide[3:0] : 4'b0000;
      end
      ST_BEAT2: begin
        ram_en    = 1'b1;
        ram_addr  = w1;
        ram_be    = wren_q ? be_wide[7:4] : 4'b0000;
        ram_wdata = wdata_wide[63:32];
      end
      default: ;
    endcase
  end

  dmem_bank #(
    .MEM_WORDS (MEM_WORDS)
  ) u_bank (
    .clk   (i_clk),
    .en    (ram_en),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Load assembly. In RESP the RAM output holds the last beat's word (no
  // access happens in RESP), so the response stays stable while stalled.
  // An aligned load only ever reads the low word of the window.
  logic [31:0] lo_data;
  logic [63:0] pair;
  logic [31:0] raw;
  logic [31:0] ext;

  always_comb begin
    lo_data = split_q ? lo_q : ram_rdata;
    pair    = {ram_rdata, lo_data};
    raw     = pair[{off_q, 3'b000} +: 32];
    case (funct3_q)
      F3_LB:   ext = {{24{raw[7]}}, raw[7:0]};
      F3_LH:   ext = {{16{raw[15]}}, raw[15:0]};
      F3_LW:   ext = raw;
      F3_LBU:  ext = {24'h0, raw[7:0]};
      F3_LHU:  ext = {16'h0, raw[15:0]};
      default: ext = 32'h0;
    endcase
  end

  assign bus.o_req_ready = req_ready_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_err   = rsp_err_q;
  assign bus.o_rsp_rdata = (rsp_valid_q && !rsp_err_q && !wren_q) ? ext : 32'h0;
  assign o_dbg_state     = state;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      wren_q      <= 1'b0;
      split_q     <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      wdata_q     <= 32'h0;
      w0_q        <= '0;
      lo_q        <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.i_req_valid) begin
            wren_q      <= bus.i_req_wren;
            funct3_q    <= bus.i_req_funct3;
            off_q       <= req_off;
            wdata_q     <= bus.i_req_wdata;
            w0_q        <= req_word;
            split_q     <= req_split;
            req_ready_q <= 1'b0;
            if (is_legal(bus.i_req_wren, bus.i_req_funct3)) begin
              state <= ST_BEAT1;
            end else begin
              // Illegal width: answer at once, RAM untouched
              state       <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end
          end
        end
        ST_BEAT1: begin
          if (split_q) begin
            state <= ST_BEAT2;
          end else begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end
        end
        ST_BEAT2: begin
          lo_q        <= ram_rdata;   // w0 data from the BEAT1 read
          state       <= ST_RESP;
          rsp_valid_q <= 1'b1;
        end
        ST_RESP: begin
          if (bus.i_rsp_ready) begin
            state       <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: byte-array model of the RAM, an expected
// response queue filled by the request driver, and one compare process that
// checks ready/valid/data/err on every falling edge.
module tb_dmem_responder;
  import lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;
  int     cyc   = 0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if bus();

  dmem_responder #(
    .MEM_WORDS (512)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          tests = 0;
  int          fails = 0;
  int          rdy_mode = 0;     // 0: always ready, 1: random, 2: held low
  logic [39:0] exp_q[$];         // {latency[6:0], err, rdata}
  int          acc_q[$];         // cycle count at acceptance
  logic [7:0]  mem_model[2048];  // byte-addressed image of the RAM

  task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Reference: response of one request and its effect on the byte image.
  // Byte addresses wrap modulo 2048, which is the word wrap at MEM_WORDS.
  function automatic logic [39:0] model_access(input logic wren, input logic [2:0] f3,
                                               input logic [31:0] addr, input logic [31:0] wdata);
    int size, off, base, lat;
    logic legal;
    logic [31:0] v;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = wren ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    off = int'(addr[1:0]);
    base = int'(addr[10:0]);
    if (!legal) return {7'd1, 1'b1, 32'h0};
    lat = (off + size > 4) ? 3 : 2;
    v = 32'h0;
    for (int i = 0; i < size; i++) begin
      if (wren) mem_model[(base + i) % 2048] = wdata[8*i +: 8];
      else      v[8*i +: 8] = mem_model[(base + i) % 2048];
    end
    if (!wren && f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
    if (!wren && f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
    if (wren) v = 32'h0;
    return {7'(lat), 1'b0, v};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (acc_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (acc_q.size() != 0) begin
      fail_now("drain");
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  task automatic issue(input logic wren, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [39:0] e);
    logic seen;
    int n;
    wait_idle();
    @(posedge clk);
    #1;
    bus.i_req_valid  = 1'b1;
    bus.i_req_wren   = wren;
    bus.i_req_funct3 = f3;
    bus.i_req_addr   = addr;
    bus.i_req_wdata  = wdata;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      seen = bus.o_req_ready;
      @(posedge clk);
      n++;
    end
    #1;
    bus.i_req_valid = 1'b0;
    e = model_access(wren, f3, addr, wdata);
    if (!seen) begin
      fail_now("accept");
    end else begin
      exp_q.push_back(e);
      acc_q.push_back(cyc);
    end
  endtask

  // Directed request whose model result is pinned to a hand-computed value
  task automatic dir(input string name, input logic wren, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int lat, input logic err, input logic [31:0] rdata);
    logic [39:0] e;
    issue(wren, f3, addr, wdata, e);
    check(name, e, {7'(lat), err, rdata});
    wait_idle();
  endtask

  // ---------------- response-ready driver ----------------
  initial begin : rdy_drv
    bus.i_rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.i_rsp_ready = 1'b1;
        1:       bus.i_rsp_ready = ($urandom_range(0, 2) != 0);
        default: bus.i_rsp_ready = 1'b0;
      endcase
    end
  end

  // ---------------- compare process ----------------
  initial begin : compare_proc
    int age;
    logic due;
    logic [39:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && acc_q.size() > 0) begin
        e   = exp_q[0];
        age = cyc - acc_q[0] + 1;
        due = (age >= int'(e[39:33]));
        check("req_ready_busy", 40'(bus.o_req_ready), 40'd0);
        check("rsp_valid", 40'(bus.o_rsp_valid), 40'(due));
        if (due) check("rsp_err_data", 40'({bus.o_rsp_err, bus.o_rsp_rdata}), 40'(e[32:0]));
        if (due && bus.o_rsp_valid && bus.i_rsp_ready) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
        end else if (age > 100) begin
          fail_now("response");
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end else if (rst_n) begin
        check("req_ready_idle", 40'(bus.o_req_ready), 40'd1);
        check("rsp_valid_idle", 40'(bus.o_rsp_valid), 40'd0);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [39:0] e;
    logic [7:0]  saved;
    logic        wren;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          sel;

    bus.i_req_valid  = 1'b0;
    bus.i_req_wren   = 1'b0;
    bus.i_req_funct3 = 3'b000;
    bus.i_req_addr   = 32'h0;
    bus.i_req_wdata  = 32'h0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", 40'(bus.o_rsp_valid), 40'd0);
    check("reset_rsp_rdata", 40'(bus.o_rsp_rdata), 40'd0);
    check("reset_rsp_err", 40'(bus.o_rsp_err), 40'd0);
    check("reset_state", 40'(dbg_state), 40'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_req_ready", 40'(bus.o_req_ready), 40'd1);

    // Known contents: word i = 0xC0DE0000 + i
    for (int i = 0; i < 512; i++) issue(1'b1, F3_SW, 32'(i * 4), 32'hC0DE0000 + 32'(i), e);
    wait_idle();

    // Aligned store then loads of every width
    dir("sw_10",  1'b1, F3_SW,  32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0);
    dir("lw_10",  1'b0, F3_LW,  32'h10, 32'h0, 2, 1'b0, 32'hDEADBEEF);
    dir("lb_13",  1'b0, F3_LB,  32'h13, 32'h0, 2, 1'b0, 32'hFFFFFFDE);
    dir("lbu_13", 1'b0, F3_LBU, 32'h13, 32'h0, 2, 1'b0, 32'h000000DE);
    dir("lh_12",  1'b0, F3_LH,  32'h12, 32'h0, 2, 1'b0, 32'hFFFFDEAD);
    dir("lhu_10", 1'b0, F3_LHU, 32'h10, 32'h0, 2, 1'b0, 32'h0000BEEF);

    // Word-crossing store and load
    dir("sw_21",  1'b1, F3_SW, 32'h21, 32'h11223344, 3, 1'b0, 32'h0);
    dir("lw_20",  1'b0, F3_LW, 32'h20, 32'h0, 2, 1'b0, 32'h22334408);
    dir("lw_24",  1'b0, F3_LW, 32'h24, 32'h0, 2, 1'b0, 32'hC0DE0011);
    dir("lw_21",  1'b0, F3_LW, 32'h21, 32'h0, 3, 1'b0, 32'h11223344);

    // Wrap from word 511 to word 0
    dir("sh_7ff",  1'b1, F3_SH,  32'h7FF, 32'h0000ABCD, 3, 1'b0, 32'h0);
    dir("lbu_7ff", 1'b0, F3_LBU, 32'h7FF, 32'h0, 2, 1'b0, 32'h000000CD);
    dir("lbu_000", 1'b0, F3_LBU, 32'h000, 32'h0, 2, 1'b0, 32'h000000AB);
    dir("lhu_7ff", 1'b0, F3_LHU, 32'h7FF, 32'h0, 3, 1'b0, 32'h0000ABCD);

    // Illegal widths
    dir("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 1, 1'b1, 32'h0);
    dir("st_f3_100", 1'b1, 3'b100, 32'h10, 32'h0, 1, 1'b1, 32'h0);
    dir("lw_10_kept", 1'b0, F3_LW, 32'h10, 32'h0, 2, 1'b0, 32'hDEADBEEF);

    // Response held while the core stalls
    rdy_mode = 2;
    issue(1'b0, F3_LW, 32'h10, 32'h0, e);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("hold_valid", 40'(bus.o_rsp_valid), 40'd1);
    check("hold_rdata", 40'(bus.o_rsp_rdata), 40'hDEADBEEF);
    check("hold_req_ready", 40'(bus.o_req_ready), 40'd0);
    rdy_mode = 0;
    wait_idle();

    // Reset during BEAT1 of a load
    issue(1'b0, F3_LW, 32'h10, 32'h0, e);
    #1 rst_n = 1'b0;
    #1;
    check("rst_b1_valid", 40'(bus.o_rsp_valid), 40'd0);
    check("rst_b1_ready", 40'(bus.o_req_ready), 40'd1);
    check("rst_b1_state", 40'(dbg_state), 40'(ST_IDLE));
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset during BEAT2 of a split store: only the first word is written
    saved = mem_model[84];
    issue(1'b1, F3_SW, 32'h51, 32'h11223344, e);
    check("sw_51", e, {7'd3, 1'b0, 32'h0});
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_b2_valid", 40'(bus.o_rsp_valid), 40'd0);
    check("rst_b2_state", 40'(dbg_state), 40'(ST_IDLE));
    exp_q.delete();
    acc_q.delete();
    mem_model[84] = saved;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    dir("lw_50_after_rst", 1'b0, F3_LW, 32'h50, 32'h0, 2, 1'b0, 32'h22334414);
    dir("lw_54_after_rst", 1'b0, F3_LW, 32'h54, 32'h0, 2, 1'b0, 32'hC0DE0015);

    // Randomized traffic, biased toward a small window and the wrap point
    for (int k = 0; k < 300; k++) begin
      rdy_mode = $urandom_range(0, 1);
      wren = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      sel  = $urandom_range(0, 3);
      addr = $urandom;
      if (sel == 1 || sel == 2) addr = (addr & 32'hFFFF_F800) | 32'($urandom_range(0, 63));
      if (sel == 3)             addr = (addr & 32'hFFFF_F800) | 32'($urandom_range(2040, 2047));
      issue(wren, f3, addr, $urandom, e);
    end
    rdy_mode = 0;
    wait_idle();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
